// File: rtl/usb_tx_pkg.sv
// Shared types and field lengths for the USB transmit path.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STUFF = 2'd2
  } tx_timer_state_t;

  localparam int SYNC_BITS  = 8;
  localparam int PID_BITS   = 8;
  localparam int CRC5_BITS  = 5;
  localparam int CRC16_BITS = 16;
  localparam int DATA_BITS  = 64;

endpackage

// File: rtl/usb_phase_counter.sv
// Modulo-CLKS_PER_BIT phase counter with synchronous clear and a wrap flag
// decoded from the registered count.
module usb_phase_counter #(
  parameter  int CLKS_PER_BIT = 8,
  localparam int PH_W         = $clog2(CLKS_PER_BIT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  output logic [PH_W-1:0] phase,
  output logic            wrap
);

  localparam logic [PH_W-1:0] LAST = PH_W'(CLKS_PER_BIT - 1);

  logic [PH_W-1:0] phase_q, phase_d;

  // Clear wins over counting; the count folds back to zero after LAST.
  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (enable) begin
      phase_d = (phase_q == LAST) ? '0 : phase_q + PH_W'(1);
    end
  end

  // Phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_d;
  end

  assign phase = phase_q;
  assign wrap  = enable && (phase_q == LAST);

endmodule

// File: rtl/usb_tx_field_timer.sv
// Bit-timing engine shared by every USB transmit field.
//
//  state | meaning
//  IDLE  | no field loaded; phase held at 0; start accepted here
//  RUN   | timing a data bit; shift strobe at SHIFT_PHASE, count at boundary
//  STUFF | timing an inserted stuffed bit; stuff strobe, count frozen
module usb_tx_field_timer
  import usb_tx_pkg::*;
#(
  parameter  int CLKS_PER_BIT   = 8,
  parameter  int SHIFT_PHASE    = 4,
  parameter  int MAX_FIELD_BITS = 64,
  localparam int CNT_W          = $clog2(MAX_FIELD_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] field_bits,
  input  logic             d_edge,
  input  logic             stuff_req,
  input  logic             abort,
  output logic             busy,
  output logic             shift_enable,
  output logic             stuff_slot,
  output logic [CNT_W-1:0] bits_sent,
  output logic             field_done,
  output logic             len_err
);

  localparam int PH_W = $clog2(CLKS_PER_BIT);
  localparam logic [PH_W-1:0]  SHIFT_PH = PH_W'(SHIFT_PHASE);
  localparam logic [CNT_W-1:0] MAX_LEN  = CNT_W'(MAX_FIELD_BITS);

  tx_timer_state_t  state_q, state_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic             len_err_q, len_err_d;

  logic [PH_W-1:0]  phase;
  logic             boundary;
  logic             ph_clear;
  logic [CNT_W-1:0] bits_inc;

  assign bits_inc = bits_q + CNT_W'(1);

  // Phase restarts on entry to a field, on every return to IDLE and on a
  // line edge; an edge on the boundary cycle still lets that boundary count.
  assign ph_clear = (state_q == IDLE) || (state_d == IDLE) || d_edge;

  usb_phase_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .clear (ph_clear),
    .enable(state_q != IDLE),
    .phase (phase),
    .wrap  (boundary)
  );

  // Next-state, bit counter and pulse decode; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    bits_d    = bits_q;
    len_d     = len_q;
    done_d    = 1'b0;
    len_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (field_bits == '0 || field_bits > MAX_LEN) begin
            len_err_d = 1'b1;
          end else begin
            len_d   = field_bits;
            bits_d  = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (boundary) begin
          bits_d = bits_inc;
          if (stuff_req) begin
            state_d = STUFF;
          end else if (bits_inc == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      STUFF: begin
        if (boundary) begin
          if (bits_q == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      bits_d    = '0;
      done_d    = 1'b0;
      len_err_d = 1'b0;
    end
  end

  // State, counters and registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bits_q    <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bits_q    <= bits_d;
      len_q     <= len_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign shift_enable = (state_q == RUN)   && (phase == SHIFT_PH);
  assign stuff_slot   = (state_q == STUFF) && (phase == SHIFT_PH);
  assign bits_sent    = bits_q;
  assign field_done   = done_q;
  assign len_err      = len_err_q;

endmodule

// File: tb/tb_usb_tx_field_timer.sv
// Scoreboard bench for usb_tx_field_timer: a reference model predicts strobe
// and pulse events into a queue, a monitor matches them against the DUT.
module tb_usb_tx_field_timer;

  localparam int CPB   = 8;
  localparam int SPH   = 4;
  localparam int MAXB  = 64;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] field_bits = '0;
  logic             d_edge = 1'b0;
  logic             stuff_req = 1'b0;
  logic             abort = 1'b0;
  logic             busy, shift_enable, stuff_slot, field_done, len_err;
  logic [CNT_W-1:0] bits_sent;

  usb_tx_field_timer #(
    .CLKS_PER_BIT(CPB),
    .SHIFT_PHASE(SPH),
    .MAX_FIELD_BITS(MAXB)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .field_bits(field_bits),
    .d_edge(d_edge), .stuff_req(stuff_req), .abort(abort),
    .busy(busy), .shift_enable(shift_enable), .stuff_slot(stuff_slot),
    .bits_sent(bits_sent), .field_done(field_done), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int cyc;
    int kind;   // {shift, stuff, done, len_err}
    int busy;
    int bits;
  } ev_t;

  ev_t q[$];

  // Reference model: a field is a sequence of bit periods of CPB clocks;
  // the data strobe lands SPH clocks into each period, stuffed periods are
  // not counted, and a line edge restarts the current period.
  int m_busy = 0, m_stf = 0, m_ph = 0, m_cnt = 0, m_len = 0;
  int m_done = 0, m_lerr = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_busy = 0; m_stf = 0; m_ph = 0; m_cnt = 0; m_len = 0;
      m_done = 0; m_lerr = 0;
    end else begin
      ev_t e;
      int  at_end, n_done, n_lerr;
      e.cyc  = cyc;
      e.kind = ((m_busy && !m_stf && m_ph == SPH) ? 8 : 0)
             + ((m_busy &&  m_stf && m_ph == SPH) ? 4 : 0)
             + (m_done ? 2 : 0) + (m_lerr ? 1 : 0);
      e.busy = m_busy;
      e.bits = m_cnt;
      if (e.kind != 0) q.push_back(e);

      at_end = m_busy && (m_ph == CPB - 1);
      n_done = 0;
      n_lerr = 0;
      if (abort) begin
        m_busy = 0; m_stf = 0; m_cnt = 0; m_ph = 0;
      end else if (!m_busy) begin
        if (start) begin
          if (field_bits == 0 || int'(field_bits) > MAXB) n_lerr = 1;
          else begin
            m_busy = 1; m_stf = 0; m_cnt = 0; m_len = int'(field_bits);
          end
        end
        m_ph = 0;
      end else begin
        if (at_end) begin
          if (m_stf) begin
            m_stf = 0;
            if (m_cnt == m_len) begin m_busy = 0; n_done = 1; end
          end else begin
            m_cnt = m_cnt + 1;
            if (stuff_req) m_stf = 1;
            else if (m_cnt == m_len) begin m_busy = 0; n_done = 1; end
          end
        end
        m_ph = (!m_busy || d_edge || at_end) ? 0 : m_ph + 1;
      end
      m_done = n_done;
      m_lerr = n_lerr;
    end
  end

  // Monitor: every DUT strobe or pulse must match the oldest predicted event.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst && (shift_enable || stuff_slot || field_done || len_err)) begin
      if (q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_kind", {28'd0, shift_enable, stuff_slot, field_done, len_err}, e.kind);
        chk("ev_busy", int'(busy), e.busy);
        chk("ev_bits", int'(bits_sent), e.bits);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; d_edge = 0; stuff_req = 0; abort = 0;
  endtask

  // Launch a field this cycle and return its start cycle.
  task automatic launch(input int fb, output int t);
    start = 1;
    field_bits = CNT_W'(fb);
    t = cyc;
  endtask

  int t, t2, n_sh, n_st, first_sh, done_at, st_at, nd;

  initial begin
    idle_inputs();
    repeat (3) step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_bits", int'(bits_sent), 0);
    chk("reset_strobes", int'(shift_enable | stuff_slot | field_done | len_err), 0);
    rst = 0;
    step();

    // 8-bit field: eight strobes, first at t+5, done at t+65
    launch(8, t);
    n_sh = 0; first_sh = -1; done_at = -1;
    for (int i = 0; i < 100 && done_at < 0; i++) begin
      step(); start = 0;
      if (shift_enable) begin n_sh++; if (first_sh < 0) first_sh = cyc - t; end
      if (field_done) begin done_at = cyc - t; chk("t1_busy_at_done", int'(busy), 0); end
    end
    chk("t1_first_shift", first_sh, 5);
    chk("t1_done_cycle", done_at, 65);
    chk("t1_shift_count", n_sh, 8);

    // 5-bit field with a stuffed bit after the third data bit
    step();
    launch(5, t);
    n_sh = 0; n_st = 0; st_at = -1; done_at = -1;
    for (int i = 0; i < 100 && done_at < 0; i++) begin
      step(); start = 0;
      stuff_req = (cyc - t == 24);
      if (shift_enable) n_sh++;
      if (stuff_slot) begin n_st++; st_at = cyc - t; end
      if (field_done) done_at = cyc - t;
    end
    stuff_req = 0;
    chk("t2_stuff_cycle", st_at, 29);
    chk("t2_stuff_count", n_st, 1);
    chk("t2_shift_count", n_sh, 5);
    chk("t2_done_cycle", done_at, 49);

    // line edge at phase 6 of the second bit realigns the period
    step();
    launch(4, t);
    first_sh = -1; done_at = -1;
    for (int i = 0; i < 100 && done_at < 0; i++) begin
      step(); start = 0;
      d_edge = (cyc - t == 15);
      if (shift_enable && cyc - t > 15 && first_sh < 0) first_sh = cyc - t;
      if (field_done) begin done_at = cyc - t; chk("t3_bits_at_done", int'(bits_sent), 4); end
    end
    d_edge = 0;
    chk("t3_shift_after_edge", first_sh, 20);
    chk("t3_done_cycle", done_at, 40);

    // illegal lengths, then start while busy
    step();
    launch(0, t);
    step(); start = 0;
    chk("t4_len_err_zero", int'(len_err), 1);
    chk("t4_busy_zero", int'(busy), 0);
    launch(65, t);
    step(); start = 0;
    chk("t4_len_err_65", int'(len_err), 1);
    chk("t4_busy_65", int'(busy), 0);
    step();
    chk("t4_len_err_clears", int'(len_err), 0);
    launch(3, t);
    done_at = -1;
    for (int i = 0; i < 60 && done_at < 0; i++) begin
      step();
      start = (cyc - t == 10);
      field_bits = (cyc - t == 10) ? CNT_W'(10) : CNT_W'(3);
      if (len_err) chk("t4_busy_start_err", 1, 0);
      if (field_done) done_at = cyc - t;
    end
    start = 0;
    chk("t4_done_ignoring_start", done_at, 25);

    // abort with three bits sent
    step();
    launch(10, t);
    for (int i = 0; i < 26; i++) begin step(); start = 0; end
    chk("t5_bits_before_abort", int'(bits_sent), 3);
    abort = 1;
    step(); abort = 0;
    chk("t5_busy_after_abort", int'(busy), 0);
    chk("t5_bits_after_abort", int'(bits_sent), 0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin step(); if (field_done) nd++; end
    chk("t5_no_done", nd, 0);

    // reset in the middle of a field
    launch(10, t);
    for (int i = 0; i < 12; i++) begin step(); start = 0; end
    rst = 1;
    #1;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_bits", int'(bits_sent), 0);
    chk("t5_rst_strobes", int'(shift_enable | stuff_slot | field_done | len_err), 0);
    step(); step();
    rst = 0;
    step();

    // back-to-back: second field launched in the field_done cycle
    launch(2, t);
    done_at = -1;
    for (int i = 0; i < 40 && done_at < 0; i++) begin
      step(); start = 0;
      if (field_done) done_at = cyc;
    end
    chk("t6_first_done_seen", (done_at >= 0) ? 1 : 0, 1);
    launch(16, t2);
    step(); start = 0;
    chk("t6_busy_next", int'(busy), 1);
    n_sh = 0; done_at = -1;
    for (int i = 0; i < 200 && done_at < 0; i++) begin
      if (shift_enable) n_sh++;
      if (field_done) done_at = cyc - t2;
      if (done_at < 0) step();
    end
    chk("t6_shift_count", n_sh, 16);
    chk("t6_done_cycle", done_at, 129);

    // randomized traffic checked only through the scoreboard
    for (int i = 0; i < 4000; i++) begin
      step();
      start      = ($urandom % 8 == 0);
      field_bits = ($urandom % 10 == 0) ? CNT_W'($urandom_range(0, 127))
                                        : CNT_W'($urandom_range(1, 12));
      stuff_req  = ($urandom % 4 == 0);
      d_edge     = ($urandom % 40 == 0);
      abort      = ($urandom % 300 == 0);
    end
    idle_inputs();
    abort = 1;
    step();
    abort = 0;
    repeat (4) step();
    chk("queue_drained", q.size(), 0);
    chk("final_idle", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
